// File: rtl/swish_tile_ctrl.sv
// rtl/swish_tile_ctrl.sv - tile sequencer streaming activations through the swish unit
// Reads, swish and writes overlap; a 3-entry result buffer absorbs write backpressure.
module swish_tile_ctrl #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_rd_addr,
   input  logic [ADDR_W-1:0] base_wr_addr,
   input  logic [ADDR_W-1:0] len,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [WIDTH-1:0]  rd_data,
   output logic [WIDTH-1:0]  sw_x,
   input  logic [WIDTH-1:0]  sw_y,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   input  logic              wr_ready
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] base_rd, base_wr, len_q;
   logic [ADDR_W-1:0] rd_cnt, wr_cnt;
   logic              rf;
   logic [WIDTH-1:0]  fifo [0:2];
   logic [1:0]        wptr, rptr, occ;
   logic [2:0]        inflight;
   logic              accept, push, pop, last_rd, last_wr;

   // inflight counts buffered results plus the one arriving this cycle
   assign inflight = {1'b0, occ} + {2'b0, rf};
   assign accept   = (state == IDLE) && start;
   assign push     = rf;
   assign pop      = wr_en && wr_ready;
   assign last_rd  = rd_en && (rd_cnt == len_q - 1'b1);
   assign last_wr  = pop && (wr_cnt == len_q - 1'b1);

   assign sw_x    = rd_data;
   assign rd_addr = base_rd + rd_cnt;
   assign wr_addr = base_wr + wr_cnt;
   assign wr_data = fifo[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (len == '0) ? DONE : RUN;
         RUN:     if (last_rd) state_nx = DRAIN;
         DRAIN:   if (last_wr) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      done  = (state == DONE);
      rd_en = (state == RUN) && (inflight < 3'd3);
      wr_en = (occ != 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_rd <= '0;
         base_wr <= '0;
         len_q   <= '0;
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         rf      <= 1'b0;
      end else begin
         rf <= rd_en;
         if (accept) begin
            base_rd <= base_rd_addr;
            base_wr <= base_wr_addr;
            len_q   <= len;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
         end else begin
            if (rd_en) rd_cnt <= rd_cnt + 1'b1;
            if (pop)   wr_cnt <= wr_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) fifo[i] <= '0;
         wptr <= 2'd0;
         rptr <= 2'd0;
         occ  <= 2'd0;
      end else begin
         if (push) begin
            fifo[wptr] <= sw_y;
            wptr       <= (wptr == 2'd2) ? 2'd0 : wptr + 2'd1;
         end
         if (pop) rptr <= (rptr == 2'd2) ? 2'd0 : rptr + 2'd1;
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_swish_tile_ctrl.sv
// tb/tb_swish_tile_ctrl.sv - randomized bench for swish_tile_ctrl against a tile-level model
module tb_swish_tile_ctrl;
   localparam int WIDTH  = 8;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_rd_addr = '0, base_wr_addr = '0, len = '0;
   logic              busy, done, rd_en, wr_en;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [WIDTH-1:0]  rd_data = '0;
   logic [WIDTH-1:0]  sw_x, sw_y, wr_data;
   logic              wr_ready = 1'b1;

   int n_chk = 0, n_fail = 0;
   int mode = 0, rdy_mode = 0;
   int edge_cnt = 0, start_edge = -1000;
   bit arm = 0, mon_on = 0;

   logic [WIDTH-1:0]  mem      [0:1023];
   logic [WIDTH-1:0]  exp_data [0:1023];
   logic [ADDR_W-1:0] exp_rd_base, exp_wr_base;
   int                exp_len;

   int rd_seen, wr_seen, first_rd, last_rd, first_wr, last_wr;
   int done_cyc, done_cnt, busy_cnt, rd_by9, wr_by9;
   bit hold_pend;
   logic [ADDR_W-1:0] hold_addr, pend_addr;
   logic [WIDTH-1:0]  hold_data;
   bit pend_rd;

   swish_tile_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .base_rd_addr(base_rd_addr), .base_wr_addr(base_wr_addr), .len(len),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .sw_x(sw_x), .sw_y(sw_y), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready)
   );

   always #5 clk = ~clk;

   // mode 0: x+1; mode 1: integer hard-swish x*clamp(x+3,0,6)/6
   function automatic logic [WIDTH-1:0] swf(input logic [WIDTH-1:0] x, input int md);
      int xi, r, y;
      xi = int'($signed(x));
      if (md == 0) y = xi + 1;
      else begin
         r = xi + 3;
         if (r < 0) r = 0;
         if (r > 6) r = 6;
         y = (xi * r) / 6;
      end
      return y[WIDTH-1:0];
   endfunction

   assign sw_y = swf(sw_x, mode);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // buffer read model and wr_ready pattern, both driven just after the edge
   always @(negedge clk) begin
      pend_rd   = rd_en;
      pend_addr = rd_addr;
   end

   always @(posedge clk) begin
      int c;
      edge_cnt = edge_cnt + 1;
      if (start && arm) begin
         start_edge = edge_cnt;
         arm = 0;
      end
      #1;
      c = edge_cnt - start_edge + 1;
      rd_data = pend_rd ? mem[pend_addr] : '0;
      case (rdy_mode)
         0:       wr_ready = 1'b1;
         1:       wr_ready = !(c >= 3 && c <= 9);
         default: wr_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   always @(negedge clk) begin
      int cyc;
      logic [ADDR_W-1:0] a;
      if (rst_n && mon_on) begin
         cyc = edge_cnt - start_edge + 1;
         check_eq("outstanding_le3", 32'(rd_seen - wr_seen <= 3), 32'd1);
         if (hold_pend) begin
            check_eq("hold_wr_en", 32'(wr_en), 32'd1);
            check_eq("hold_wr_addr", 32'(wr_addr), 32'(hold_addr));
            check_eq("hold_wr_data", 32'(wr_data), 32'(hold_data));
         end
         hold_pend = wr_en && !wr_ready;
         hold_addr = wr_addr;
         hold_data = wr_data;
         if (rd_en) begin
            a = exp_rd_base + ADDR_W'(rd_seen);
            check_eq("rd_addr", 32'(rd_addr), 32'(a));
            if (rd_seen == 0) first_rd = cyc;
            last_rd = cyc;
            rd_seen++;
         end
         if (wr_en && wr_ready) begin
            a = exp_wr_base + ADDR_W'(wr_seen);
            check_eq("wr_addr", 32'(wr_addr), 32'(a));
            if (wr_seen < exp_len) check_eq("wr_data", 32'(wr_data), 32'(exp_data[wr_seen]));
            else check_eq("extra_write", 32'd1, 32'd0);
            if (wr_seen == 0) first_wr = cyc;
            last_wr = cyc;
            wr_seen++;
         end
         if (done) begin
            done_cyc = cyc;
            done_cnt++;
         end
         if (busy) busy_cnt++;
         if (cyc == 9) begin
            rd_by9 = rd_seen;
            wr_by9 = wr_seen;
         end
      end
   end

   task automatic begin_tile(input logic [ADDR_W-1:0] brd, input logic [ADDR_W-1:0] bwr,
                             input logic [ADDR_W-1:0] ln, input int md, input int rm);
      logic [ADDR_W-1:0] a;
      mode = md; rdy_mode = rm;
      exp_rd_base = brd; exp_wr_base = bwr; exp_len = int'(ln);
      for (int k = 0; k < exp_len; k++) begin
         a = brd + ADDR_W'(k);
         exp_data[k] = swf(mem[a], md);
      end
      rd_seen = 0; wr_seen = 0; first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
      done_cyc = -1; done_cnt = 0; busy_cnt = 0; rd_by9 = -1; wr_by9 = -1; hold_pend = 0;
      @(posedge clk); #1;
      start = 1'b1; base_rd_addr = brd; base_wr_addr = bwr; len = ln; arm = 1;
      @(posedge clk); #1;
      start = 1'b0; mon_on = 1;
      base_rd_addr = ADDR_W'($urandom); base_wr_addr = ADDR_W'($urandom); len = ADDR_W'($urandom);
   endtask

   task automatic finish_tile();
      bit got;
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1;
      end
      check_eq("done_seen", 32'(got), 32'd1);
      @(negedge clk);
      check_eq("busy_after_done", 32'(busy), 32'd0);
      mon_on = 0;
      check_eq("rd_count", 32'(rd_seen), 32'(exp_len));
      check_eq("wr_count", 32'(wr_seen), 32'(exp_len));
      check_eq("done_pulses", 32'(done_cnt), 32'd1);
      check_eq("busy_cycles", 32'(busy_cnt), 32'(done_cyc));
   endtask

   task automatic run_tile(input logic [ADDR_W-1:0] brd, input logic [ADDR_W-1:0] bwr,
                           input logic [ADDR_W-1:0] ln, input int md, input int rm, input bit poke);
      begin_tile(brd, bwr, ln, md, rm);
      if (poke) begin
         @(posedge clk); #1;
         start = 1'b1; len = 10'd3; base_rd_addr = 10'h155; base_wr_addr = 10'h2AA;
         @(posedge clk); #1;
         start = 1'b0;
      end
      finish_tile();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = WIDTH'($urandom);

      repeat (3) @(negedge clk);
      check_eq("reset_outputs", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      mem[10'h010] = 8'hFE; mem[10'h011] = 8'hFF; mem[10'h012] = 8'h00; mem[10'h013] = 8'h05;
      run_tile(10'h010, 10'h200, 10'd4, 0, 0, 0);
      check_eq("t1_first_rd", 32'(first_rd), 32'd1);
      check_eq("t1_last_rd", 32'(last_rd), 32'd4);
      check_eq("t1_first_wr", 32'(first_wr), 32'd3);
      check_eq("t1_last_wr", 32'(last_wr), 32'd6);
      check_eq("t1_done_cyc", 32'(done_cyc), 32'd7);
      check_eq("t1_exp_last", 32'(exp_data[3]), 32'h06);

      run_tile(10'(($urandom)), 10'(($urandom)), 10'd8, 1, 1, 0);
      check_eq("bp_reads_by9", 32'(rd_by9), 32'd3);
      check_eq("bp_writes_by9", 32'(wr_by9), 32'd0);

      run_tile(10'h123, 10'h321, 10'd0, 0, 0, 0);
      check_eq("len0_done_cyc", 32'(done_cyc), 32'd1);

      run_tile(10'h3FE, 10'h3FD, 10'd4, 0, 0, 0);
      check_eq("wrap_last_wr", 32'(last_wr), 32'd6);

      begin_tile(10'h040, 10'h080, 10'd6, 0, 0);
      for (int i = 0; i < 10 && (edge_cnt - start_edge + 1) < 3; i++) @(negedge clk);
      rst_n = 1'b0;
      mon_on = 0;
      #1;
      check_eq("abort_outputs", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("abort_no_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      run_tile(10'h050, 10'h090, 10'd2, 0, 0, 0);
      check_eq("post_abort_done_cyc", 32'(done_cyc), 32'd5);

      run_tile(10'h0A0, 10'h1B0, 10'd10, 1, 2, 1);

      for (int k = 0; k < 17; k++) mem[10'h100 + k] = WIDTH'(k - 8);
      run_tile(10'h100, 10'h300, 10'd17, 1, 2, 0);

      for (int t = 0; t < 4; t++)
         run_tile(10'($urandom), 10'($urandom), 10'($urandom_range(1, 24)),
                  int'($urandom_range(0, 1)), 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
